tdm_demux: RTL

//  Time-division demultiplexer; the receive end of a round-robin lane mux.

---
 rtl/tdm_demux.sv | 123 ++++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
// Receive end of a round-robin lane mux: reassembles LANES serial beats into one parallel frame word.
// Optional error reporting (err_pulse / err_count) is enabled by defining TDM_DEMUX_ERR_EN.
module tdm_demux #(
    parameter int WIDTH = 1,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sof,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(LANES)-1:0] lane_sel
`ifdef TDM_DEMUX_ERR_EN
    ,
    output logic                     err_pulse,
    output logic [7:0]               err_count
`endif
);

    localparam int SLOT_W = $clog2(LANES);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    state_t                   state_q, state_d;
    logic [SLOT_W-1:0]        lane_q, lane_d;
    logic [LANES*WIDTH-1:0]   asm_q, asm_d;
    logic [LANES*WIDTH-1:0]   out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     accept;

    // Only the frame-completing beat can be stalled, and only while the previous word is still held.
    assign in_ready = !(state_q == COLLECT && lane_q == LAST_SLOT && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (in_sof) begin
                // A sof always restarts assembly, whether expected or mid-frame.
                asm_d              = '0;
                asm_d[WIDTH-1:0]   = in_data;
                lane_d             = SLOT_W'(1);
                state_d            = COLLECT;
            end else if (state_q == COLLECT && lane_q != '0) begin
                asm_d[lane_q*WIDTH +: WIDTH] = in_data;
                if (lane_q == LAST_SLOT) begin
                    lane_d      = '0;
                    out_data_d  = asm_d;
                    out_valid_d = 1'b1;
                end else begin
                    lane_d = lane_q + SLOT_W'(1);
                end
            end else begin
                state_d = HUNT;
                lane_d  = '0;
            end
        end
    end

    // NOTE: state uses non-blocking assignments only; the assembly buffer is reset too so a stale partial never leaks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            lane_q      <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign lane_sel  = lane_q;

`ifdef TDM_DEMUX_ERR_EN
    logic       err_event;
    logic       err_pulse_q;
    logic [7:0] err_count_q;

    // Error when sof arrives off slot 0, or slot 0 arrives without sof.
    assign err_event = accept && state_q == COLLECT && (in_sof == (lane_q != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= err_event;
            if (err_event && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
`endif

endmodule
